// File: rtl/pipelined_rca.sv
// pipelined_rca: ripple-carry adder/subtractor split into STAGES registered carry segments.
// Operands skew forward, sum segments deskew, so a whole result leaves the last stage together.
module pipelined_rca #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int SEG = WIDTH / STAGES;

    logic w_en;

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || WIDTH % STAGES != 0) begin : g_bad
        $error("pipelined_rca: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_st
        // w_a/w_b hold only the operand bits not yet consumed, lowest segment first
        logic [WIDTH-g*SEG-1:0]   w_a, w_b;
        logic                     w_c, w_v, w_co;
        logic [SEG-1:0]           w_seg;
        logic [(g+1)*SEG-1:0]     w_s, r_s;
        logic                     r_v, r_c;
        if (g == 0) begin : g_head
            assign w_a = a;
            assign w_b = sub ? ~b : b;
            assign w_c = sub | cin;
            assign w_v = in_valid;
            assign w_s = w_seg;
        end else begin : g_body
            assign w_a = g_st[g-1].g_sk.r_a;
            assign w_b = g_st[g-1].g_sk.r_b;
            assign w_c = g_st[g-1].r_c;
            assign w_v = g_st[g-1].r_v;
            assign w_s = {w_seg, g_st[g-1].r_s};
        end
        assign {w_co, w_seg} = {1'b0, w_a[SEG-1:0]} + {1'b0, w_b[SEG-1:0]} + {{SEG{1'b0}}, w_c};
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_en) begin
                r_v <= w_v;
                r_c <= w_co;
                r_s <= w_s;
            end
        end
        if (g < STAGES - 1) begin : g_sk
            logic [WIDTH-(g+1)*SEG-1:0] r_a, r_b;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_en) begin
                    r_a <= w_a[WIDTH-g*SEG-1:SEG];
                    r_b <= w_b[WIDTH-g*SEG-1:SEG];
                end
            end
        end else begin : g_ov
            logic r_ov;
            // carry into the MSB is a ^ b ^ sum at that bit
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_ov <= 1'b0;
                else if (w_en) r_ov <= w_a[SEG-1] ^ w_b[SEG-1] ^ w_seg[SEG-1] ^ w_co;
            end
        end
    end

    assign out_valid = g_st[STAGES-1].r_v;
    assign sum       = g_st[STAGES-1].r_s;
    assign cout      = g_st[STAGES-1].r_c;
    assign ovf       = g_st[STAGES-1].g_ov.r_ov;
    assign w_en      = !out_valid || out_ready;
    assign in_ready  = w_en;
endmodule

// File: doc/pipelined_rca.md
# pipelined_rca

Parametrised, pipelined ripple-carry adder/subtractor. The carry chain is split into STAGES equal segments, with a register boundary after each segment. It accepts one operation per cycle through a valid/ready handshake and returns results in order after STAGES enabled cycles. It succeeds the fixed-width combinational ripple-carry adder as the datapath arithmetic block wherever WIDTH-bit adds must close timing at high clock rates.

## Interface
- WIDTH, 16, operand and sum width in bits; must be ≥ 1
- STAGES, 4, number of pipeline segments; 1 ≤ STAGES ≤ WIDTH, WIDTH % STAGES == 0 (elaboration error otherwise); SEG = WIDTH/STAGES
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, asynchronous and active-high
- in_valid  input  1  operation present on a/b/cin/sub
- in_ready  output  1  block can accept an operation this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in, used only when sub=0
- sub  input  1  1: compute a − b (a + ~b + 1, cin ignored); 0: a + b + cin
- out_valid  output  1  result present on sum/cout/ovf
- out_ready  input  1  consumer accepts result this cycle
- sum  output  WIDTH  result, modulo 2^WIDTH
- cout  output  1  carry out of MSB (for sub: 1 = no borrow)
- ovf  output  1  two's-complement signed overflow (carry into MSB XOR carry out of MSB)

## Operation
- Stage k (0..STAGES−1) adds bits [k·SEG +: SEG] of A and B' (B' = sub ? ~b : b) plus the carry registered by stage k−1. Stage 0 carry-in = sub ? 1 : cin.
- Operand segments not yet consumed are carried forward in skew registers. Finished sum segments are carried forward in deskew registers, so all WIDTH sum bits, cout and ovf of one operation leave the final stage together.
- ovf is computed in the last stage from its internal carry into bit WIDTH−1 and its carry out.
- Each stage holds a valid bit. Pipeline enable en = !out_valid || out_ready. Every stage register (data and valid) loads only when en=1. When en=0, everything holds, including sum/cout/ovf.
- in_ready = en (combinational from out_valid/out_ready; no combinational path from in_valid).
- Accept: in_valid && in_ready at an edge. On an enabled edge with in_valid=0, a bubble (valid=0) enters stage 0. Bubbles are not collapsed.
- Results are delivered strictly in acceptance order; no operation is dropped or duplicated.
- STAGES=1 degenerates to a single registered adder with latency 1.

## Timing
- Reset (asynchronous, immediate): all valid bits 0, out_valid=0, sum=0, cout=0, ovf=0, all internal carry/skew registers 0. in_ready=1 while rst is deasserted and the pipeline is empty.
- Reset mid-operation discards all in-flight operations. The first edge after rst falls may accept a new operation.
- Latency: an operation accepted at edge N appears with out_valid=1 after edge N+STAGES−1 when en stayed 1 throughout. It is counted as STAGES enabled edges including the accepting edge, plus one extra cycle for every cycle with en=0.
- Throughput: one operation per cycle while out_ready=1.
- Simultaneous out handshake and new accept in the same cycle is required: the pipeline shifts, and the presented result is consumed.
- out_valid=1 && out_ready=0: sum/cout/ovf stable, in_ready=0, upstream must hold.
- a/b/cin/sub are sampled only on an accepting edge. They are don't-care otherwise.

## Test plan
(WIDTH=16, STAGES=4 unless noted; out_ready=1 unless noted)
- a=0x0001, b=0x0002, cin=0, sub=0 -> sum=0x0003, cout=0, ovf=0, out_valid high exactly 4 enabled edges after acceptance.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry rippled through all 4 stages). Also a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
- a=0x7FFF, b=0x0001, add -> sum=0x8000, ovf=1, cout=0. Then sub, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0. Then sub, a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1, cout=1.
- Stream 64 random back-to-back operations while out_ready toggles pseudo-randomly -> every result matches the golden model, in order, with no loss or duplication. Outputs stay stable while stalled. in_ready == !out_valid || out_ready every cycle.
- Assert rst asynchronously (between edges) with 3 operations in flight -> out_valid, sum, cout, ovf go to 0 immediately. After release, a new operation 0x1234+0x1111 -> 0x2345 with nominal latency, and no stale results.
- Re-run the first three scenarios with STAGES=1 (latency 1) and with WIDTH=8, STAGES=8 (latency 8). Include 0xFF+0x01 -> sum=0x00, cout=1.
